// File: rtl/nina_spi_pkg.sv
// ---------------------------------------------------------------------------
// nina_spi_pkg
// Shared definitions for the nina_spi_master byte-stream SPI master.
//   spi_state_e : FSM state encoding (IDLE, SETUP, SHIFT, WAIT, HOLD)
//   SPI_BYTE_W  : bits per SPI transfer
//   BIT_CNT_W   : width of the per-byte bit counter
//   max2()      : constant helper used for sizing counters
// ---------------------------------------------------------------------------
package nina_spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int BIT_CNT_W  = $clog2(SPI_BYTE_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// ---------------------------------------------------------------------------
// spi_sclk_div
// SCLK timing generator. Counts CLK_DIV system clocks per SCLK half-period
// and emits single-cycle strobes marking the end of each half-period.
// The low phase always comes first after enable; counter and phase are
// held at zero while disabled so every byte starts from a clean phase.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_en    : run the divider (high only while shifting)
//   o_rise  : last cycle of a low phase  -> SCLK should rise
//   o_fall  : last cycle of a high phase -> SCLK should fall
// ---------------------------------------------------------------------------
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;   // 0 = low half-period, 1 = high half-period
  logic             w_end;

  assign w_end = (r_cnt == CNT_END);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_end) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_rise = i_en & w_end & ~r_phase;
  assign o_fall = i_en & w_end &  r_phase;

endmodule

// File: rtl/nina_spi_master.sv
// ---------------------------------------------------------------------------
// nina_spi_master
// SPI mode-0 byte-stream master for the spichain SPI-to-Avalon protocol.
// Upstream bytes arrive on a valid/ready stream; a byte flagged LAST closes
// the chip-select frame after it has been shifted out.
//
// Ports
//   iCLK, iRESETn          : system clock, async active-low reset
//   iTX_DATA/LAST/VALID    : upstream byte, end-of-frame flag, byte offered
//   oTX_READY              : byte accepted when VALID & READY (IDLE / WAIT)
//   oRX_DATA, oRX_VALID    : received byte with one-cycle valid pulse
//   oBUSY                  : a CS frame is in progress
//   oSCLK, oMOSI, iMISO    : SPI bus, CPOL=0 CPHA=0, MSB first
//   oCS_n                  : chip select, active-low
//
// Parameters
//   CLK_DIV  : iCLK cycles per SCLK half-period (>=2)
//   CS_SETUP : cycles CS_n is low before the first SCLK low phase (>=1)
//   CS_HOLD  : cycles CS_n stays low after the last SCLK fall (>=1)
// ---------------------------------------------------------------------------
module nina_spi_master
  import nina_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                  iCLK,
  input  logic                  iRESETn,
  input  logic [SPI_BYTE_W-1:0] iTX_DATA,
  input  logic                  iTX_LAST,
  input  logic                  iTX_VALID,
  output logic                  oTX_READY,
  output logic [SPI_BYTE_W-1:0] oRX_DATA,
  output logic                  oRX_VALID,
  output logic                  oBUSY,
  output logic                  oSCLK,
  output logic                  oMOSI,
  input  logic                  iMISO,
  output logic                  oCS_n
);

  localparam int TMR_MAX = max2(CS_SETUP, CS_HOLD);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0]     SETUP_END = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0]     HOLD_END  = TMR_W'(CS_HOLD - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(SPI_BYTE_W - 1);

  spi_state_e r_state;
  spi_state_e w_state_nxt;

  logic                  w_accept;
  logic                  w_tx_ready;
  logic                  w_shift_en;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_last_fall;

  // Bit 7 goes straight to MOSI on accept, so only the 7 remaining bits
  // are kept for shifting.
  logic [SPI_BYTE_W-2:0] r_tx_sh;
  logic [SPI_BYTE_W-1:0] r_rx_sh;
  logic [SPI_BYTE_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_last;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [TMR_W-1:0]      r_tmr;
  logic                  r_cs_n;
  logic                  r_sclk;
  logic                  r_mosi;

  assign w_shift_en  = (r_state == ST_SHIFT);
  assign w_last_fall = w_fall && (r_bit_cnt == LAST_BIT);

  spi_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .i_clk   (iCLK),
    .i_rst_n (iRESETn),
    .i_en    (w_shift_en),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // State register
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_tx_ready  = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_tx_ready = 1'b1;
        if (iTX_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_tmr == SETUP_END) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_fall) begin
          w_state_nxt = r_last ? ST_HOLD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // CS stays asserted indefinitely until upstream offers the next byte.
        w_tx_ready = 1'b1;
        if (iTX_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (r_tmr == HOLD_END) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and SPI pin registers
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_last     <= 1'b0;
      r_bit_cnt  <= '0;
      r_tmr      <= '0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      // Timer restarts on every state change, so SETUP and HOLD share it.
      if (w_state_nxt != r_state) begin
        r_tmr <= '0;
      end else if ((r_state == ST_SETUP) || (r_state == ST_HOLD)) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end

      if (w_accept) begin
        r_tx_sh   <= iTX_DATA[SPI_BYTE_W-2:0];
        r_last    <= iTX_LAST;
        r_mosi    <= iTX_DATA[SPI_BYTE_W-1];
        r_bit_cnt <= '0;
        r_cs_n    <= 1'b0;
      end

      if (r_state == ST_SHIFT) begin
        // MISO is sampled raw: the slave launches its data from oSCLK,
        // which we generate, so it is already settled at our rise strobe.
        if (w_rise) begin
          r_sclk  <= 1'b1;
          r_rx_sh <= {r_rx_sh[SPI_BYTE_W-2:0], iMISO};
        end
        if (w_fall) begin
          r_sclk    <= 1'b0;
          r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
          if (w_last_fall) begin
            // MOSI keeps bit 0 until the next accept or end of frame.
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
          end else begin
            r_mosi  <= r_tx_sh[SPI_BYTE_W-2];
            r_tx_sh <= {r_tx_sh[SPI_BYTE_W-3:0], 1'b0};
          end
        end
      end

      if ((r_state == ST_HOLD) && (r_tmr == HOLD_END)) begin
        r_cs_n <= 1'b1;
        r_mosi <= 1'b0;
      end
    end
  end

  assign oTX_READY = w_tx_ready;
  assign oBUSY     = (r_state != ST_IDLE);
  assign oRX_DATA  = r_rx_data;
  assign oRX_VALID = r_rx_valid;
  assign oSCLK     = r_sclk;
  assign oMOSI     = r_mosi;
  assign oCS_n     = r_cs_n;

endmodule

// File: tb/tb_nina_spi_master.sv
// ---------------------------------------------------------------------------
// tb_nina_spi_master
// Bench for nina_spi_master with CLK_DIV=2, CS_SETUP=2, CS_HOLD=2.
// A behavioural SPI slave shifts on oSCLK and returns bytes from a response
// table (or loops MOSI back). Frames are described by {bytes, gaps,
// responses, expected rx, expected CS-low time}; expectations for random
// frames come from frame-level arithmetic on the protocol timing rules.
// ---------------------------------------------------------------------------
module tb_nina_spi_master;

  localparam int D   = 2;
  localparam int S   = 2;
  localparam int H   = 2;
  localparam int LIM = 3000;

  logic       iCLK = 1'b0;
  logic       iRESETn = 1'b0;
  logic [7:0] iTX_DATA = 8'h00;
  logic       iTX_LAST = 1'b0;
  logic       iTX_VALID = 1'b0;
  logic       oTX_READY;
  logic [7:0] oRX_DATA;
  logic       oRX_VALID;
  logic       oBUSY;
  logic       oSCLK;
  logic       oMOSI;
  logic       iMISO;
  logic       oCS_n;

  nina_spi_master #(
    .CLK_DIV  (D),
    .CS_SETUP (S),
    .CS_HOLD  (H)
  ) dut (
    .iCLK      (iCLK),
    .iRESETn   (iRESETn),
    .iTX_DATA  (iTX_DATA),
    .iTX_LAST  (iTX_LAST),
    .iTX_VALID (iTX_VALID),
    .oTX_READY (oTX_READY),
    .oRX_DATA  (oRX_DATA),
    .oRX_VALID (oRX_VALID),
    .oBUSY     (oBUSY),
    .oSCLK     (oSCLK),
    .oMOSI     (oMOSI),
    .iMISO     (iMISO),
    .oCS_n     (oCS_n)
  );

  always #5 iCLK = ~iCLK;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [7:0] resp_arr [1024];
  logic       loopback = 1'b0;
  int         s_byte_idx = 0;
  logic [2:0] s_bits = 3'd0;
  logic [7:0] s_rx = 8'h00;
  logic [7:0] s_rx_q [$];

  assign iMISO = loopback ? oMOSI : resp_arr[s_byte_idx & 1023][3'd7 - s_bits];

  always @(posedge oSCLK or negedge oCS_n) begin
    logic [7:0] t;
    if (oSCLK) begin
      t = {s_rx[6:0], oMOSI};
      s_rx <= t;
      if (s_bits == 3'd7) begin
        s_rx_q.push_back(t);
        s_bits     <= 3'd0;
        s_byte_idx <= s_byte_idx + 1;
      end else begin
        s_bits <= s_bits + 3'd1;
      end
    end else begin
      s_bits <= 3'd0;
    end
  end

  // ---------------- bus monitor ----------------
  logic       prev_sclk = 1'b0;
  logic       prev_cs   = 1'b1;
  int         rise_q [$];
  logic [7:0] rx_q [$];
  int         cs_falls = 0;
  int         cs_low_cyc = 0;
  int         rdy_low_cyc = 0;

  always @(negedge iCLK) begin
    prev_sclk <= oSCLK;
    prev_cs   <= oCS_n;
    if (oSCLK && !prev_sclk) rise_q.push_back(cyc);
    if (!oCS_n && prev_cs) cs_falls <= cs_falls + 1;
    if (!oCS_n) cs_low_cyc <= cs_low_cyc + 1;
    if (!oCS_n && oTX_READY) rdy_low_cyc <= rdy_low_cyc + 1;
    if (oRX_VALID) rx_q.push_back(oRX_DATA);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: wait bound of %0d cycles expired", nm, LIM);
  endtask

  // Offer a byte and return after it has been accepted (VALID left high).
  task automatic put_byte(input logic [7:0] d, input logic last, output int acc_c);
    int cnt;
    cnt = 0;
    iTX_DATA  = d;
    iTX_LAST  = last;
    iTX_VALID = 1'b1;
    while (!oTX_READY && cnt < LIM) begin
      @(negedge iCLK);
      cnt++;
    end
    if (cnt >= LIM) bound_fail("accept");
    acc_c = cyc;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  // ---------------- frame runner ----------------
  logic [7:0] fr_d    [4];
  logic [7:0] fr_resp [4];
  logic [7:0] fr_exp  [4];
  int         fr_gap  [4];

  task automatic run_frame(input string tag, input int n, input bit hold, input bit lb,
                           input int exp_cs, input int exp_rdy);
    int acc [4];
    int b_rise, b_rx, b_srx, b_fall, b_cs, b_rdy, cnt, lat;
    loopback = lb;
    for (int i = 0; i < n; i++) resp_arr[(s_byte_idx + i) & 1023] = fr_resp[i];
    b_rise = rise_q.size();
    b_rx   = rx_q.size();
    b_srx  = s_rx_q.size();
    b_fall = cs_falls;
    b_cs   = cs_low_cyc;
    b_rdy  = rdy_low_cyc;
    for (int i = 0; i < n; i++) begin
      put_byte(fr_d[i], (i == n - 1), acc[i]);
      if (i < n - 1 && !hold) begin
        iTX_VALID = 1'b0;
        cnt = 0;
        while (!oRX_VALID && cnt < LIM) begin
          @(negedge iCLK);
          cnt++;
        end
        if (cnt >= LIM) bound_fail({tag, ".rxvalid"});
        repeat (fr_gap[i]) @(negedge iCLK);
      end
    end
    // VALID stays high through the rest of the frame; it must not be taken
    // before the master is back in IDLE.
    cnt = 0;
    while (oBUSY && cnt < LIM) begin
      @(negedge iCLK);
      cnt++;
    end
    iTX_VALID = 1'b0;
    if (cnt >= LIM) bound_fail({tag, ".idle"});
    repeat (2) @(negedge iCLK);

    chk({tag, ".cs_falls"}, cs_falls - b_fall, 1);
    chk({tag, ".cs_low_cycles"}, cs_low_cyc - b_cs, exp_cs);
    chk({tag, ".ready_in_frame"}, rdy_low_cyc - b_rdy, exp_rdy);
    chk({tag, ".sclk_rises"}, rise_q.size() - b_rise, 8 * n);
    chk({tag, ".rx_valid_count"}, rx_q.size() - b_rx, n);
    for (int i = 0; i < n; i++) begin
      if (rx_q.size() > b_rx + i)
        chk($sformatf("%s.rx%0d", tag, i), rx_q[b_rx + i], fr_exp[i]);
      if (s_rx_q.size() > b_srx + i)
        chk($sformatf("%s.mosi%0d", tag, i), s_rx_q[b_srx + i], fr_d[i]);
      if (rise_q.size() > b_rise + 8 * i) begin
        lat = rise_q[b_rise + 8 * i] - acc[i];
        chk($sformatf("%s.start%0d", tag, i), lat, (i == 0) ? (1 + S + D) : (1 + D));
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       tag;
    int          n;
    logic [31:0] d;       // byte i in bits [8i+7:8i]
    logic [31:0] resp;
    logic [31:0] exp_rx;
    int          gap;
    bit          hold;
    bit          lb;
    int          exp_cs;
    int          exp_rdy;
  } vec_t;

  vec_t vt [4];

  initial begin
    int acc_c, b_rx, cnt, n, g, sum_gap;
    bit hold;

    vt[0] = '{"single_a5",  1, 32'h000000A5, 32'h0000003C, 32'h0000003C,  0, 1'b1, 1'b0,  36,  0};
    vt[1] = '{"three_held", 3, 32'h00017B4A, 32'h00C35A96, 32'h00C35A96,  0, 1'b1, 1'b0, 102,  2};
    vt[2] = '{"gap10",      2, 32'h00005AC3, 32'h0000E781, 32'h0000E781, 10, 1'b0, 1'b0,  79, 11};
    vt[3] = '{"loopback",   2, 32'h000000FF, 32'h00000000, 32'h000000FF,  0, 1'b1, 1'b1,  69,  1};

    for (int i = 0; i < 1024; i++) resp_arr[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge iCLK);
    chk("rst.cs_n",   oCS_n,     1'b1);
    chk("rst.sclk",   oSCLK,     1'b0);
    chk("rst.mosi",   oMOSI,     1'b0);
    chk("rst.rxdata", oRX_DATA,  8'h00);
    chk("rst.rxvld",  oRX_VALID, 1'b0);
    chk("rst.busy",   oBUSY,     1'b0);
    chk("rst.ready",  oTX_READY, 1'b1);
    iRESETn = 1'b1;
    repeat (2) @(negedge iCLK);

    // Directed frames
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] dw, rw, ew;
        dw = vt[v].d;
        rw = vt[v].resp;
        ew = vt[v].exp_rx;
        fr_d[i]    = dw[8*i +: 8];
        fr_resp[i] = rw[8*i +: 8];
        fr_exp[i]  = ew[8*i +: 8];
        fr_gap[i]  = vt[v].gap;
      end
      run_frame(vt[v].tag, vt[v].n, vt[v].hold, vt[v].lb, vt[v].exp_cs, vt[v].exp_rdy);
    end
    loopback = 1'b0;

    // WAIT state levels while VALID is withheld
    resp_arr[s_byte_idx & 1023]       = 8'h12;
    resp_arr[(s_byte_idx + 1) & 1023] = 8'h34;
    put_byte(8'h81, 1'b0, acc_c);
    iTX_VALID = 1'b0;
    cnt = 0;
    while (!oRX_VALID && cnt < LIM) begin
      @(negedge iCLK);
      cnt++;
    end
    if (cnt >= LIM) bound_fail("wait.rxvalid");
    repeat (5) @(negedge iCLK);
    chk("wait.cs_n",  oCS_n,     1'b0);
    chk("wait.sclk",  oSCLK,     1'b0);
    chk("wait.ready", oTX_READY, 1'b1);
    chk("wait.busy",  oBUSY,     1'b1);
    put_byte(8'h18, 1'b1, acc_c);
    iTX_VALID = 1'b0;
    cnt = 0;
    while (oBUSY && cnt < LIM) begin
      @(negedge iCLK);
      cnt++;
    end
    if (cnt >= LIM) bound_fail("wait.idle");
    repeat (2) @(negedge iCLK);

    // Asynchronous reset after the 3rd rising edge of a frame
    b_rx = rx_q.size();
    resp_arr[s_byte_idx & 1023] = 8'h6D;
    begin
      int b_rise;
      b_rise = rise_q.size();
      put_byte(8'h96, 1'b1, acc_c);
      iTX_VALID = 1'b0;
      cnt = 0;
      while (rise_q.size() < b_rise + 3 && cnt < LIM) begin
        @(negedge iCLK);
        cnt++;
      end
      if (cnt >= LIM) bound_fail("areset.rise3");
    end
    #2 iRESETn = 1'b0;
    #1;
    chk("areset.cs_n",  oCS_n,     1'b1);
    chk("areset.sclk",  oSCLK,     1'b0);
    chk("areset.mosi",  oMOSI,     1'b0);
    chk("areset.busy",  oBUSY,     1'b0);
    repeat (3) @(negedge iCLK);
    iRESETn = 1'b1;
    repeat (2) @(negedge iCLK);
    chk("areset.ready_after", oTX_READY, 1'b1);
    chk("areset.no_rxvalid", rx_q.size() - b_rx, 0);
    fr_d[0] = 8'h96; fr_resp[0] = 8'h6D; fr_exp[0] = 8'h6D; fr_gap[0] = 0;
    run_frame("after_reset", 1, 1'b1, 1'b0, S + 16 * D + H, 0);

    // Randomized frames against frame-level timing arithmetic
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(4, 1);
      hold = 1'($urandom_range(1, 0));
      sum_gap = 0;
      for (int i = 0; i < 4; i++) begin
        fr_d[i]    = 8'($urandom);
        fr_resp[i] = 8'($urandom);
        fr_exp[i]  = fr_resp[i];
        g = hold ? 0 : $urandom_range(5, 0);
        fr_gap[i]  = g;
        if (i < n - 1) sum_gap += g + 1;
      end
      run_frame($sformatf("rnd%0d", f), n, hold, 1'b0,
                S + n * 16 * D + sum_gap + H, sum_gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
